// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the EX/MEM memory-access stage: memop codes, exception
// codes and byte-enable patterns.
package mem_access_ctrl_pkg;

  typedef enum logic [3:0] {
    MemNone = 4'd0,
    MemLb   = 4'd1,
    MemLbu  = 4'd2,
    MemLh   = 4'd3,
    MemLhu  = 4'd4,
    MemLw   = 4'd5,
    MemSb   = 4'd6,
    MemSh   = 4'd7,
    MemSw   = 4'd8
  } memop_e;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [3:0] BeNone     = 4'b0000;
  localparam logic [3:0] BeByte0    = 4'b0001;
  localparam logic [3:0] BeLowHalf  = 4'b0011;
  localparam logic [3:0] BeHighHalf = 4'b1100;
  localparam logic [3:0] BeWord     = 4'b1111;

endpackage

// File: rtl/mem_access_ctrl_be_decode.sv
// Combinational decode of a memop and the low address bits into byte enables,
// load/store class, unsigned flag and alignment fault.
module mem_be_decode
  import mem_access_ctrl_pkg::*;
(
  input  logic [3:0] memop_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] be_o,
  output logic       u_o,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       misalign_o
);

  always_comb begin
    be_o       = BeNone;
    u_o        = 1'b0;
    is_load_o  = 1'b0;
    is_store_o = 1'b0;
    misalign_o = 1'b0;
    case (memop_i)
      MemLb, MemLbu, MemSb: begin
        be_o = BeByte0 << addr_lo_i;
      end
      MemLh, MemLhu, MemSh: begin
        be_o       = addr_lo_i[1] ? BeHighHalf : BeLowHalf;
        misalign_o = addr_lo_i[0];
      end
      MemLw, MemSw: begin
        be_o       = BeWord;
        misalign_o = |addr_lo_i;
      end
      default: ;
    endcase
    // Opcodes 9-15 fall through as "none" and never assert either class.
    is_load_o  = (memop_i >= 4'(MemLb)) && (memop_i <= 4'(MemLw));
    is_store_o = (memop_i >= 4'(MemSb)) && (memop_i <= 4'(MemSw));
    u_o        = (memop_i == 4'(MemLbu)) || (memop_i == 4'(MemLhu));
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// EX/MEM pipeline register driving the data memory, with address-error
// detection, a held AdEL/AdES request and single-write guarantee for stalled stores.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned DM_WORDS = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_rt_data,
  input  logic [31:0] ex_pc,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  output logic [29:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic        dm_u,
  output logic [31:0] dm_din,
  output logic        dm_read,
  output logic        dm_wr,
  output logic        mem_valid,
  output logic [31:0] mem_alu_result,
  output logic [4:0]  mem_rd,
  output logic        mem_regwrite,
  output logic        mem_is_load,
  output logic        exc_req,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_badvaddr,
  output logic [31:0] exc_epc,
  input  logic        exc_ack
);

  localparam logic [29:0] DmWordsW = 30'(DM_WORDS);

  logic        valid_q, valid_d;
  logic [3:0]  memop_q, memop_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] rt_q, rt_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  rd_q, rd_d;
  logic        regwrite_q, regwrite_d;
  logic        store_done_q, store_done_d;
  logic        exc_req_q, exc_req_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] exc_badvaddr_q, exc_badvaddr_d;
  logic [31:0] exc_epc_q, exc_epc_d;

  logic [3:0] be;
  logic       u, is_load, is_store, misalign, err;

  mem_be_decode u_be_decode (
    .memop_i    (memop_q),
    .addr_lo_i  (alu_q[1:0]),
    .be_o       (be),
    .u_o        (u),
    .is_load_o  (is_load),
    .is_store_o (is_store),
    .misalign_o (misalign)
  );

  assign err = (is_load | is_store) & (misalign | (alu_q[31:2] >= DmWordsW));

  always_comb begin
    dm_addr        = alu_q[31:2];
    dm_din         = rt_q;
    dm_u           = valid_q & u;
    dm_read        = valid_q & is_load & ~err & ~exc_req_q;
    // A store still sitting in MEM when reset arrives must not write.
    dm_wr          = valid_q & is_store & ~err & ~exc_req_q & ~store_done_q & ~rst;
    dm_be          = (dm_read | dm_wr) ? be : BeNone;
    mem_valid      = valid_q;
    mem_alu_result = alu_q;
    mem_rd         = rd_q;
    mem_regwrite   = regwrite_q & valid_q & ~err;
    mem_is_load    = valid_q & is_load;
    exc_req        = exc_req_q;
    exc_code       = exc_code_q;
    exc_badvaddr   = exc_badvaddr_q;
    exc_epc        = exc_epc_q;
  end

  always_comb begin
    valid_d    = valid_q;
    memop_d    = memop_q;
    alu_d      = alu_q;
    rt_d       = rt_q;
    pc_d       = pc_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    if (flush) begin
      valid_d = 1'b0;
      memop_d = 4'(MemNone);
    end else if (!stall) begin
      valid_d    = ex_valid;
      memop_d    = ex_memop;
      alu_d      = ex_alu_result;
      rt_d       = ex_rt_data;
      pc_d       = ex_pc;
      rd_d       = ex_rd;
      regwrite_d = ex_regwrite;
    end
    store_done_d = (stall && !flush) ? (store_done_q | dm_wr) : 1'b0;
  end

  // Ack wins over a coincident new error; a still-resident fault re-latches later.
  always_comb begin
    exc_req_d      = exc_req_q;
    exc_code_d     = exc_code_q;
    exc_badvaddr_d = exc_badvaddr_q;
    exc_epc_d      = exc_epc_q;
    if (exc_req_q) begin
      if (exc_ack) exc_req_d = 1'b0;
    end else if (valid_q && err && !exc_ack) begin
      exc_req_d      = 1'b1;
      exc_code_d     = is_store ? EXC_ADES : EXC_ADEL;
      exc_badvaddr_d = alu_q;
      exc_epc_d      = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= 1'b0;
      memop_q        <= 4'(MemNone);
      alu_q          <= '0;
      rt_q           <= '0;
      pc_q           <= '0;
      rd_q           <= '0;
      regwrite_q     <= 1'b0;
      store_done_q   <= 1'b0;
      exc_req_q      <= 1'b0;
      exc_code_q     <= '0;
      exc_badvaddr_q <= '0;
      exc_epc_q      <= '0;
    end else begin
      valid_q        <= valid_d;
      memop_q        <= memop_d;
      alu_q          <= alu_d;
      rt_q           <= rt_d;
      pc_q           <= pc_d;
      rd_q           <= rd_d;
      regwrite_q     <= regwrite_d;
      store_done_q   <= store_done_d;
      exc_req_q      <= exc_req_d;
      exc_code_q     <= exc_code_d;
      exc_badvaddr_q <= exc_badvaddr_d;
      exc_epc_q      <= exc_epc_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: an instruction-level model predicts each
// cycle's outputs into a queue that a negedge monitor drains and compares.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ex_valid, ex_regwrite, exc_ack;
  logic [3:0]  ex_memop;
  logic [31:0] ex_alu_result, ex_rt_data, ex_pc;
  logic [4:0]  ex_rd;
  logic [29:0] dm_addr;
  logic [3:0]  dm_be;
  logic        dm_u, dm_read, dm_wr;
  logic [31:0] dm_din;
  logic        mem_valid, mem_regwrite, mem_is_load;
  logic [31:0] mem_alu_result;
  logic [4:0]  mem_rd;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_badvaddr, exc_epc;

  mem_access_ctrl #(.DM_WORDS(24)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_memop(ex_memop), .ex_alu_result(ex_alu_result),
    .ex_rt_data(ex_rt_data), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .dm_addr(dm_addr), .dm_be(dm_be), .dm_u(dm_u), .dm_din(dm_din),
    .dm_read(dm_read), .dm_wr(dm_wr),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .mem_is_load(mem_is_load),
    .exc_req(exc_req), .exc_code(exc_code), .exc_badvaddr(exc_badvaddr),
    .exc_epc(exc_epc), .exc_ack(exc_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [3:0]  be;
    logic [29:0] addr;
    bit          u;
    logic [31:0] din;
    bit          rw;
    bit          ld;
    bit          valid;
    logic [31:0] alu;
    logic [4:0]  rdst;
    bit          xreq;
    logic [4:0]  xcode;
    logic [31:0] xbad;
    logic [31:0] xepc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  bit done = 0;

  // Model of the instruction currently in MEM plus the exception/write bookkeeping.
  bit          m_valid, m_rw, m_pend, m_written;
  int          m_op;
  logic [31:0] m_a, m_rt, m_pc, m_bad, m_epc;
  logic [4:0]  m_rd, m_code;

  function automatic bit is_ld(int op);
    return op >= 1 && op <= 5;
  endfunction

  function automatic bit is_st(int op);
    return op >= 6 && op <= 8;
  endfunction

  function automatic bit addr_err(int op, logic [31:0] a);
    if (!is_ld(op) && !is_st(op)) return 0;
    if ((op == 3 || op == 4 || op == 7) && (a % 2 != 0)) return 1;
    if ((op == 5 || op == 8) && (a % 4 != 0)) return 1;
    return (a / 4) >= 24;
  endfunction

  function automatic logic [3:0] be_of(int op, logic [31:0] a);
    if (op == 1 || op == 2 || op == 6) return 4'(1 << (a % 4));
    if (op == 3 || op == 4 || op == 7) return (a % 4 >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic bit exp_rd();
    return m_valid && is_ld(m_op) && !addr_err(m_op, m_a) && !m_pend;
  endfunction

  function automatic bit exp_wr();
    return m_valid && is_st(m_op) && !addr_err(m_op, m_a) && !m_pend && !m_written && !rst;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic model_edge();
    bit e, w;
    e = addr_err(m_op, m_a);
    w = exp_wr();
    if (rst) begin
      m_valid = 0; m_op = 0; m_a = 0; m_rt = 0; m_pc = 0; m_rd = 0; m_rw = 0;
      m_written = 0; m_pend = 0; m_code = 0; m_bad = 0; m_epc = 0;
    end else begin
      if (m_pend) begin
        if (exc_ack) m_pend = 0;
      end else if (m_valid && e && !exc_ack) begin
        m_pend = 1;
        m_code = is_st(m_op) ? 5'd5 : 5'd4;
        m_bad  = m_a;
        m_epc  = m_pc;
      end
      m_written = (stall && !flush) ? (m_written | w) : 0;
      if (flush) begin
        m_valid = 0;
        m_op    = 0;
      end else if (!stall) begin
        m_valid = ex_valid; m_op = int'(ex_memop); m_a = ex_alu_result;
        m_rt = ex_rt_data; m_pc = ex_pc; m_rd = ex_rd; m_rw = ex_regwrite;
      end
    end
  endtask

  task automatic step(bit r, bit st, bit fl, bit ack, bit v, logic [3:0] op,
                      logic [31:0] a, logic [31:0] rt, logic [31:0] pc,
                      logic [4:0] rd, bit rw);
    exp_t e;
    @(posedge clk);
    #1;
    model_edge();
    rst = r; stall = st; flush = fl; exc_ack = ack; ex_valid = v; ex_memop = op;
    ex_alu_result = a; ex_rt_data = rt; ex_pc = pc; ex_rd = rd; ex_regwrite = rw;
    e.rd    = exp_rd();
    e.wr    = exp_wr();
    e.be    = (e.rd || e.wr) ? be_of(m_op, m_a) : 4'd0;
    e.addr  = 30'(m_a >> 2);
    e.u     = m_valid && (m_op == 2 || m_op == 4);
    e.din   = m_rt;
    e.rw    = m_rw && m_valid && !addr_err(m_op, m_a);
    e.ld    = m_valid && is_ld(m_op);
    e.valid = m_valid;
    e.alu   = m_a;
    e.rdst  = m_rd;
    e.xreq  = m_pend;
    e.xcode = m_code;
    e.xbad  = m_bad;
    e.xepc  = m_epc;
    q.push_back(e);
  endtask

  task automatic idle(bit ack = 0);
    step(0, 0, 0, ack, 0, 4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("dm_read", 32'(dm_read), 32'(e.rd));
        chk("dm_wr", 32'(dm_wr), 32'(e.wr));
        chk("dm_be", 32'(dm_be), 32'(e.be));
        chk("mem_valid", 32'(mem_valid), 32'(e.valid));
        chk("mem_regwrite", 32'(mem_regwrite), 32'(e.rw));
        chk("mem_is_load", 32'(mem_is_load), 32'(e.ld));
        chk("mem_alu_result", mem_alu_result, e.alu);
        chk("mem_rd", 32'(mem_rd), 32'(e.rdst));
        chk("exc_req", 32'(exc_req), 32'(e.xreq));
        if (dm_read || dm_wr || e.rd || e.wr) begin
          chk("dm_addr", 32'(dm_addr), 32'(e.addr));
          chk("dm_u", 32'(dm_u), 32'(e.u));
          chk("dm_din", dm_din, e.din);
        end
        if (exc_req || e.xreq) begin
          chk("exc_code", 32'(exc_code), 32'(e.xcode));
          chk("exc_badvaddr", exc_badvaddr, e.xbad);
          chk("exc_epc", exc_epc, e.xepc);
        end
      end
    end
  end

  initial begin : stimulus
    bit          ack;
    logic [31:0] a;
    rst = 1; stall = 0; flush = 0; exc_ack = 0; ex_valid = 0; ex_memop = 0;
    ex_alu_result = 0; ex_rt_data = 0; ex_pc = 0; ex_rd = 0; ex_regwrite = 0;
    m_valid = 0; m_op = 0; m_a = 0; m_rt = 0; m_pc = 0; m_rd = 0; m_rw = 0;
    m_written = 0; m_pend = 0; m_code = 0; m_bad = 0; m_epc = 0;
    step(1, 0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
    step(0, 0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
    // SB byte lane 2, one-cycle write
    step(0, 0, 0, 0, 1, 4'd6, 32'h6, 32'hAB, 32'h00400000, 5'd0, 0);
    idle(); idle();
    // LHU / LH upper half
    step(0, 0, 0, 0, 1, 4'd4, 32'hA, 32'h0, 32'h00400004, 5'd3, 1);
    step(0, 0, 0, 0, 1, 4'd3, 32'hA, 32'h0, 32'h00400008, 5'd4, 1);
    idle(); idle();
    // Misaligned LW -> AdEL held until ack
    step(0, 0, 0, 0, 1, 4'd5, 32'h5, 32'h0, 32'h00400020, 5'd5, 1);
    idle(); idle(); idle(); idle(1); idle(); idle();
    // SW beyond DM_WORDS -> AdES
    step(0, 0, 0, 0, 1, 4'd8, 32'h60, 32'h1234, 32'h00400030, 5'd0, 0);
    idle(); idle(); idle(1); idle();
    // Stalled SW writes once, next SW writes normally
    step(0, 0, 0, 0, 1, 4'd8, 32'h8, 32'hCAFE, 32'h00400040, 5'd0, 0);
    step(0, 1, 0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
    step(0, 1, 0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
    step(0, 1, 0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
    step(0, 0, 0, 0, 1, 4'd8, 32'hC, 32'hBEEF, 32'h00400044, 5'd0, 0);
    idle(); idle();
    // Flush beats stall; reset with SH in MEM
    step(0, 1, 1, 0, 1, 4'd8, 32'h10, 32'h55, 32'h00400050, 5'd0, 0);
    step(0, 0, 0, 0, 1, 4'd7, 32'h2, 32'h77, 32'h00400054, 5'd0, 0);
    step(1, 0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
    idle(); idle();
    for (int i = 0; i < 600; i++) begin
      ack = m_pend && ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 127));
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, ack, $urandom_range(0, 4) != 0,
           4'($urandom_range(0, 15)), a, $urandom(), $urandom(),
           5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1);
    end
    idle(); idle();
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
EX/MEM pipeline stage of the interrupt-capable pipelined CPU, sitting directly upstream of the data memory. It latches the EX-stage memory operation and decodes it into the data memory's word address, byte enables, unsigned flag, store data, read enable and write enable. It detects address errors (AdEL/AdES), suppresses the faulting access and raises a held exception request toward the interrupt/CP0 logic. It also guarantees that a stalled store writes exactly once.

Parameters:
DM_WORDS, 24, number of 32-bit words in data memory; a word index >= DM_WORDS is an address error.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
stall  in  1  hold the MEM register contents
flush  in  1  load a bubble into the MEM register
ex_valid  in  1  EX stage holds a real instruction
ex_memop  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none
ex_alu_result  in  32  effective address, or ALU result for non-memory ops
ex_rt_data  in  32  store data
ex_pc  in  32  instruction PC
ex_rd  in  5  destination register
ex_regwrite  in  1  instruction writes the register file
dm_addr  out  30  word address, equal to mem_alu_result[31:2]
dm_be  out  4  byte enables
dm_u  out  1  unsigned load
dm_din  out  32  store data, unshifted; the memory takes the byte/half from din[7:0]/din[15:0]
dm_read  out  1  load enable
dm_wr  out  1  write enable, sampled by memory at the next posedge
mem_valid, mem_alu_result[31:0], mem_rd[4:0], mem_regwrite, mem_is_load  out  toward WB and forwarding
exc_req  out  1  exception pending
exc_code  out  5  4 = AdEL, 5 = AdES
exc_badvaddr  out  32  faulting address
exc_epc  out  32  PC of the faulting instruction
exc_ack  in  1  CP0 accepted the exception

Behaviour:
- Reset: all MEM register fields and all outputs are 0. This includes exc_req, exc_code, exc_badvaddr, exc_epc and store_done.
- MEM register update at each posedge:
  - rst: clear.
  - Else flush: valid=0, memop=0 (flush beats stall).
  - Else stall: hold.
  - Else: capture the ex_* inputs.
- Outputs are combinational from the MEM register. Latency from EX to DM request is 1 cycle, and a store commits at the following edge.
- Decode with a = mem_alu_result:
  - Byte ops: be = 0001 << a[1:0].
  - Half ops: be = a[1] ? 1100 : 0011.
  - Word ops: be = 1111.
  - dm_u = 1 only for LBU and LHU.
- Address error occurs when any of these holds:
  - a half op with a[0] = 1;
  - a word op with a[1:0] != 0;
  - a memory op with a[31:2] >= DM_WORDS.
- Access enables:
  - dm_read = valid & load & ~err & ~exc_req.
  - dm_wr = valid & store & ~err & ~exc_req & ~store_done.
  - When dm_read and dm_wr are both 0, dm_be = 0000.
- store_done:
  - Set at a posedge where dm_wr = 1 and stall = 1.
  - Cleared when the register advances (no stall), on flush and on rst.
  - Effect: a stalled store writes once only.
- mem_regwrite = reg_regwrite & valid & ~err. mem_is_load = valid & load.
- Exception handshake:
  - At a posedge with valid & err & ~exc_req, set exc_req and latch exc_code, exc_badvaddr = a and exc_epc = reg_pc.
  - exc_req holds until a posedge with exc_ack = 1, then clears.
  - If a new error and exc_ack coincide, the ack wins; the new error latches only if it is still in MEM on the next cycle.
  - While exc_req = 1, all DM accesses are suppressed and further errors are ignored.
- Reset mid-operation: a pending store in MEM is discarded and no write occurs at the reset edge, because dm_wr is forced 0 while rst = 1.

Decomposition:
- Shared package: memop encodings, exception codes (EXC_ADEL = 4, EXC_ADES = 5) and be constants.
- One natural sub-module, mem_be_decode: purely combinational decode of memop and a[1:0] into be, u, is_load, is_store and misalign.

Test Plan:
1. SB with a = 0x00000006, rt = 0x000000AB, no stall: the cycle after capture shows dm_be = 0100 and dm_wr = 1; a 1-cycle pulse, dm_addr = 1.
2. LHU a = 0x0000000A: dm_be = 1100, dm_u = 1, dm_read = 1, mem_regwrite = 1. LH at the same address: dm_u = 0.
3. LW a = 0x00000005, pc = 0x00400020: no dm_read, mem_regwrite = 0. Next cycle exc_req = 1, exc_code = 4, badvaddr = 0x5, epc = 0x00400020. It holds for 3 cycles until exc_ack and clears the cycle after.
4. SW a = 0x00000060 (word 24 >= DM_WORDS): dm_wr never asserts, exc_code = 5.
5. SW a = 0x8 with stall held 3 cycles: dm_wr = 1 for exactly one cycle, then 0 while stalled; the next store after release writes normally.
6. Stall and flush together with SW in EX: the MEM register becomes a bubble, dm_wr = 0. rst asserted with SH in MEM: no write and all outputs 0 the following cycle.
